// File: rtl/hex_display_ctrl.sv
// ----------------------------------------------------------------------------
// hex_display_ctrl
//   Avalon-MM slave driving N_DIGITS seven-segment digits. Holds one register
//   per digit plus a control register, decodes hex nibbles to segments and
//   applies global enable, per-digit blanking and a timed blink.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   Avalon word address (0 = CTRL, 1..N_DIGITS = DIGIT[k-1])
//   chipselect  in   Avalon select
//   write_n     in   Avalon write strobe, active low
//   writedata   in   Avalon write data (32 bits)
//   readdata    out  Avalon read data, combinational, zero wait states
//   hex_out     out  segments, digit k on [7k+6:7k], bit 0 = segment a
//
// Register map
//   CTRL   bit0 EN (reset 1), bit1 BCLR (write-only, restarts blink, reads 0)
//   DIGIT  bits[3:0] VAL, bit4 BLANK (reset 1), bit5 BLINK
//
// Optional build macro HEX_DISP_RAW_EN
//   Adds DIGIT bit6 RAW and bits[14:8] SEG (gfedcba, active-high). With RAW=1
//   the digit shows SEG instead of the hex decode of VAL.
// ----------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int N_DIGITS       = 6,
    parameter int ADDR_W         = 4,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [7*N_DIGITS-1:0] hex_out
);

    // A single-cycle half-period still needs a 1-bit counter that sits at 0.
    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    // Hex nibble to lit segments, gfedcba, active-high.
    function automatic logic [6:0] f_hex_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Map active-high lit pattern to the board's pin polarity.
    function automatic logic [6:0] f_polarity(input logic [6:0] lit);
        return (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    logic                   r_en;
    logic [3:0]             r_val [N_DIGITS];
    logic [N_DIGITS-1:0]    r_blank;
    logic [N_DIGITS-1:0]    r_blink;
`ifdef HEX_DISP_RAW_EN
    logic [N_DIGITS-1:0]    r_raw;
    logic [6:0]             r_seg [N_DIGITS];
`endif
    logic [CNT_W-1:0]       r_bcnt;
    logic                   r_bphase;
    logic [7*N_DIGITS-1:0]  r_hex;

    logic                   w_wr;
    logic                   w_wr_ctrl;
    logic                   w_bclr;
    logic [7*N_DIGITS-1:0]  w_hex_next;
    logic                   w_unused_wdata;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_ctrl = w_wr & (address == '0);
    assign w_bclr    = w_wr_ctrl & writedata[1];

    // Only a subset of writedata bits is stored.
    assign w_unused_wdata = ^writedata;

    // ---- register stage: CTRL and DIGIT registers ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_en <= writedata[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                r_val[k]   <= 4'h0;
                r_blank[k] <= 1'b1;
                r_blink[k] <= 1'b0;
`ifdef HEX_DISP_RAW_EN
                r_raw[k]   <= 1'b0;
                r_seg[k]   <= 7'h00;
`endif
            end
        end else begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (w_wr && (address == ADDR_W'(k + 1))) begin
                    r_val[k]   <= writedata[3:0];
                    r_blank[k] <= writedata[4];
                    r_blink[k] <= writedata[5];
`ifdef HEX_DISP_RAW_EN
                    r_raw[k]   <= writedata[6];
                    r_seg[k]   <= writedata[14:8];
`endif
                end
            end
        end
    end

    // Blink timebase: BCLR restart wins over a wrap on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt   <= '0;
            r_bphase <= 1'b0;
        end else if (w_bclr) begin
            r_bcnt   <= '0;
            r_bphase <= 1'b0;
        end else if (r_bcnt == CNT_LAST) begin
            r_bcnt   <= '0;
            r_bphase <= ~r_bphase;
        end else begin
            r_bcnt   <= r_bcnt + CNT_W'(1);
        end
    end

    // Read mux: purely address-decoded, unused bits stay 0.
    always_comb begin
        readdata = '0;
        if (address == '0) begin
            readdata[0] = r_en;
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            if (address == ADDR_W'(k + 1)) begin
                readdata[3:0] = r_val[k];
                readdata[4]   = r_blank[k];
                readdata[5]   = r_blink[k];
`ifdef HEX_DISP_RAW_EN
                readdata[6]    = r_raw[k];
                readdata[14:8] = r_seg[k];
`endif
            end
        end
    end

    // ---- display stage: per-digit glyph select and darkening ----
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic [6:0] w_glyph;
        logic       w_dark;

`ifdef HEX_DISP_RAW_EN
        assign w_glyph = r_raw[k] ? r_seg[k] : f_hex_decode(r_val[k]);
`else
        assign w_glyph = f_hex_decode(r_val[k]);
`endif
        assign w_dark  = ~r_en | r_blank[k] | (r_blink[k] & r_bphase);
        assign w_hex_next[7*k +: 7] = f_polarity(w_dark ? 7'h00 : w_glyph);
    end

    // ---- output stage: registered segment drive ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= {N_DIGITS{SEG_OFF}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign hex_out = r_hex;

endmodule
